// File: rtl/riscv_defines.sv
// Shared RISC-V bus widths and the memory responder state encoding.
package riscv_defines;
    localparam int RISCV_ADDR_WIDTH = 32;
    localparam int RISCV_WORD_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_resp_state_e;
endpackage

// File: rtl/mem_resp_ram.sv
// Word-organised storage with byte-lane write enables and a registered read port.
module mem_resp_ram
    import riscv_defines::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        rd_en_i,
    input  logic                        rd_clr_i,
    input  logic [3:0]                  we_i,
    input  logic [IDX_W-1:0]            idx_i,
    input  logic [RISCV_WORD_WIDTH-1:0] wdata_i,
    output logic [RISCV_WORD_WIDTH-1:0] rdata_o
);
    logic [RISCV_WORD_WIDTH-1:0] mem_q [DEPTH_WORDS];
    logic [RISCV_WORD_WIDTH-1:0] rdata_q;

    // Read register samples the pre-write contents on the same edge a write lands.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (rd_en_i) begin
            rdata_q <= rd_clr_i ? '0 : mem_q[idx_i];
        end
    end

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (we_i[b]) begin
                mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/mem_responder.sv
// Single-port memory responder with programmable response latency.
// Optional MEM_RESPONDER_ERR_EN adds mem_err_o for misaligned/out-of-range accesses.
module mem_responder
    import riscv_defines::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        mem_valid_i,
    output logic                        mem_ready_o,
    input  logic [RISCV_ADDR_WIDTH-1:0] mem_addr_i,
    input  logic [RISCV_WORD_WIDTH-1:0] mem_wdata_i,
    input  logic [3:0]                  mem_we_i,
    output logic [RISCV_WORD_WIDTH-1:0] mem_rdata_o
`ifdef MEM_RESPONDER_ERR_EN
    ,
    output logic                        mem_err_o
`endif
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);

    mem_resp_state_e             state_q;
    logic [3:0]                  cnt_q;
    logic [RISCV_ADDR_WIDTH-1:0] addr_q;
    logic [RISCV_WORD_WIDTH-1:0] wdata_q;
    logic [3:0]                  we_q;
    logic                        ready_q;
    logic                        in_resp;
    logic [3:0]                  ram_we;
    logic                        addr_err;

    assign in_resp = (state_q == RESP);

`ifdef MEM_RESPONDER_ERR_EN
    localparam logic [63:0] ADDR_LIMIT = 64'(DEPTH_WORDS) * 64'd4;
    logic err_q;

    assign addr_err = (addr_q[1:0] != 2'b00) || ({32'b0, addr_q} >= ADDR_LIMIT);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= in_resp && addr_err;
        end
    end

    assign mem_err_o = err_q;
`else
    logic unused_addr_bits;

    assign addr_err         = 1'b0;
    assign unused_addr_bits = ^addr_q;
`endif

    // rst_n gates the write so a reset landing on the RESP edge commits nothing.
    assign ram_we = (in_resp && rst_n && !addr_err) ? we_q : 4'b0000;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            ready_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 4'b0000;
        end else begin
            ready_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (mem_valid_i) begin
                        addr_q  <= mem_addr_i;
                        wdata_q <= mem_wdata_i;
                        we_q    <= mem_we_i;
                        cnt_q   <= 4'(WAIT_CYCLES);
                        state_q <= (WAIT_CYCLES > 0) ? WAIT : RESP;
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    mem_resp_ram #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .IDX_W      (IDX_W)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .rd_en_i (in_resp),
        .rd_clr_i(addr_err),
        .we_i    (ram_we),
        .idx_i   (addr_q[2 +: IDX_W]),
        .wdata_i (wdata_q),
        .rdata_o (mem_rdata_o)
    );

    assign mem_ready_o = ready_q;
endmodule
